// File: rtl/disp_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// disp_pkg: shared character codes, parity modes and FSM state type for the
// baud-rate display formatter.
// Revision: 1.0
// ---------------------------------------------------------------------------
package disp_pkg;

  localparam logic [4:0] CH_0   = 5'd0;
  localparam logic [4:0] CH_1   = 5'd1;
  localparam logic [4:0] CH_2   = 5'd2;
  localparam logic [4:0] CH_3   = 5'd3;
  localparam logic [4:0] CH_4   = 5'd4;
  localparam logic [4:0] CH_5   = 5'd5;
  localparam logic [4:0] CH_6   = 5'd6;
  localparam logic [4:0] CH_7   = 5'd7;
  localparam logic [4:0] CH_8   = 5'd8;
  localparam logic [4:0] CH_9   = 5'd9;
  localparam logic [4:0] CH_OFF = 5'd29;

  localparam logic [1:0] PAR_NONE = 2'd0;
  localparam logic [1:0] PAR_ODD  = 2'd1;
  localparam logic [1:0] PAR_EVEN = 2'd2;

  localparam int N_DIG   = 6;
  localparam int SAT_MAX = 999999;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_LOAD  = 2'd2
  } state_t;

endpackage
`default_nettype wire

// File: rtl/bcd_add3.sv
`default_nettype none
// ---------------------------------------------------------------------------
// bcd_add3: double-dabble correction cell, adds 3 to a BCD nibble >= 5.
// Revision: 1.0
// ---------------------------------------------------------------------------
module bcd_add3 (
  input  logic [3:0] din,
  output logic [3:0] dout
);

  assign dout = (din >= 4'd5) ? din + 4'd3 : din;

endmodule
`default_nettype wire

// File: rtl/baud_disp_fmt.sv
`default_nettype none
// ---------------------------------------------------------------------------
// baud_disp_fmt: converts a baud rate to six seven-segment character codes
// via bit-serial double dabble; parity mode shown on the decimal points.
// Optional leading-zero blanking: define BAUD_DISP_LZB_EN.
// Revision: 1.0
// ---------------------------------------------------------------------------
module baud_disp_fmt
  import disp_pkg::*;
#(
  parameter int W = 20
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] baud_val,
  input  logic [1:0]   parity,
  output logic         busy,
  output logic         done,
  output logic [5:0]   dig0,
  output logic [5:0]   dig1,
  output logic [5:0]   dig2,
  output logic [5:0]   dig3,
  output logic [5:0]   dig4,
  output logic [5:0]   dig5
);

  localparam int CW = $clog2(W + 1);
  localparam logic [W-1:0] SAT_W = W'(SAT_MAX);
  localparam logic [5:0] DIG_RST = {1'b0, CH_OFF};

  state_t state, state_nx;
  logic           accept, shift_en, load_en;
  logic [W-1:0]   bin;
  logic [23:0]    bcd, bcd_adj;
  logic [CW-1:0]  cnt;
  logic [1:0]     par_q;
  logic [5:0]     dig_q  [N_DIG];
  logic [5:0]     dig_nx [N_DIG];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_IDLE;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE:  if (start) state_nx = ST_SHIFT;
      ST_SHIFT: if (cnt == CW'(W - 1)) state_nx = ST_LOAD;
      ST_LOAD:  state_nx = ST_IDLE;
      default:  state_nx = ST_IDLE;
    endcase
  end

  always_comb begin
    busy     = (state != ST_IDLE);
    accept   = (state == ST_IDLE) && start;
    shift_en = (state == ST_SHIFT);
    load_en  = (state == ST_LOAD);
  end

  for (genvar i = 0; i < N_DIG; i++) begin : g_add3
    bcd_add3 u_add3 (
      .din  (bcd[i*4 +: 4]),
      .dout (bcd_adj[i*4 +: 4])
    );
  end

  // Saturating before conversion keeps every nibble within 0..9.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bin   <= '0;
      bcd   <= '0;
      cnt   <= '0;
      par_q <= PAR_NONE;
    end else if (accept) begin
      bin   <= (baud_val > SAT_W) ? SAT_W : baud_val;
      bcd   <= '0;
      cnt   <= '0;
      par_q <= parity;
    end else if (shift_en) begin
      bcd   <= {bcd_adj[22:0], bin[W-1]};
      bin   <= {bin[W-2:0], 1'b0};
      cnt   <= cnt + 1'b1;
    end
  end

  always_comb begin
`ifdef BAUD_DISP_LZB_EN
    logic seen;
    seen = 1'b0;
`endif
    for (int i = N_DIG - 1; i >= 0; i--) begin
      dig_nx[i] = {1'b0, 1'b0, bcd[i*4 +: 4]};
`ifdef BAUD_DISP_LZB_EN
      if (bcd[i*4 +: 4] != 4'd0) seen = 1'b1;
      if (!seen && i != 0) dig_nx[i] = {1'b0, CH_OFF};
`endif
    end
    // Decimal points go on after blanking so a blank digit can still show one.
    if (par_q == PAR_ODD)  dig_nx[0][5] = 1'b1;
    if (par_q == PAR_EVEN) dig_nx[1][5] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      done <= 1'b0;
      for (int i = 0; i < N_DIG; i++) dig_q[i] <= DIG_RST;
    end else begin
      done <= load_en;
      if (load_en) begin
        for (int i = 0; i < N_DIG; i++) dig_q[i] <= dig_nx[i];
      end
    end
  end

  assign dig0 = dig_q[0];
  assign dig1 = dig_q[1];
  assign dig2 = dig_q[2];
  assign dig3 = dig_q[3];
  assign dig4 = dig_q[4];
  assign dig5 = dig_q[5];

endmodule
`default_nettype wire

// File: tb/tb_baud_disp_fmt.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_baud_disp_fmt: directed vectors with a scoreboard queue and a monitor.
// Revision: 1.0
// ---------------------------------------------------------------------------
module tb_baud_disp_fmt;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [19:0] baud_val = '0;
  logic [1:0]  parity = '0;
  logic        busy, done;
  logic [5:0]  dig0, dig1, dig2, dig3, dig4, dig5;

  baud_disp_fmt #(.W(20)) dut (
    .clk(clk), .rst(rst), .start(start), .baud_val(baud_val), .parity(parity),
    .busy(busy), .done(done),
    .dig0(dig0), .dig1(dig1), .dig2(dig2), .dig3(dig3), .dig4(dig4), .dig5(dig5)
  );

  always #10 clk = ~clk;

  typedef struct {
    logic [35:0] digs;
    int          cyc;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;
  logic prev_done = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: every done pulse pops one expected result.
  always @(negedge clk) begin
    logic [35:0] act;
    exp_t e;
    act = {dig5, dig4, dig3, dig2, dig1, dig0};
    if (done) begin
      check("done_width", int'(prev_done), 0);
      if (q.size() == 0) begin
        check("unexpected_done", 1, 0);
      end else begin
        e = q.pop_front();
        check("done_cycle", cyc, e.cyc);
        check("busy_at_done", int'(busy), 0);
        for (int i = 0; i < 6; i++)
          check($sformatf("dig%0d", i), int'(act[i*6 +: 6]), int'(e.digs[i*6 +: 6]));
      end
    end
    prev_done <= done;
  end

  // Issue a start; returns the edge count at which it was accepted.
  task automatic issue(input logic [19:0] v, input logic [1:0] p,
                       input logic [35:0] exp_plain, input logic [35:0] exp_lzb,
                       input bit push, output int acc);
    exp_t e;
    start = 1'b1; baud_val = v; parity = p;
    @(posedge clk); #1;
    start = 1'b0;
    acc = cyc;
    check("busy_after_start", int'(busy), 1);
`ifdef BAUD_DISP_LZB_EN
    e.digs = exp_lzb;
`else
    e.digs = exp_plain;
`endif
    e.cyc = acc + 21;
    if (push) q.push_back(e);
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while (q.size() != 0 && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    check("drain_timeout", q.size(), 0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic wait_until(input int target);
    while (cyc < target) begin
      @(posedge clk); #1;
    end
  endtask

  initial begin
    int e0;
    int e1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_dig0", int'(dig0), 29);
    check("rst_dig5", int'(dig5), 29);
    check("rst_busy", int'(busy), 0);
    rst = 1'b1;
    @(posedge clk); #1;
    check("idle_busy", int'(busy), 0);
    check("idle_done", int'(done), 0);

    // 115200, odd parity
    issue(20'd115200, 2'd1,
          {6'd1, 6'd1, 6'd5, 6'd2, 6'd0, 6'd32},
          {6'd1, 6'd1, 6'd5, 6'd2, 6'd0, 6'd32}, 1'b1, e0);
    wait_idle(60);
    // 9600, even parity
    issue(20'd9600, 2'd2,
          {6'd0, 6'd0, 6'd9, 6'd6, 6'd32, 6'd0},
          {6'd29, 6'd29, 6'd9, 6'd6, 6'd32, 6'd0}, 1'b1, e0);
    wait_idle(60);
    // zero, no parity
    issue(20'd0, 2'd0,
          {6'd0, 6'd0, 6'd0, 6'd0, 6'd0, 6'd0},
          {6'd29, 6'd29, 6'd29, 6'd29, 6'd29, 6'd0}, 1'b1, e0);
    wait_idle(60);
    // saturation, parity code 3 treated as none
    issue(20'd1048575, 2'd3,
          {6'd9, 6'd9, 6'd9, 6'd9, 6'd9, 6'd9},
          {6'd9, 6'd9, 6'd9, 6'd9, 6'd9, 6'd9}, 1'b1, e0);
    wait_idle(60);
    // blanked digit still carries its decimal point
    issue(20'd5, 2'd2,
          {6'd0, 6'd0, 6'd0, 6'd0, 6'd32, 6'd5},
          {6'd29, 6'd29, 6'd29, 6'd29, 6'd61, 6'd5}, 1'b1, e0);
    wait_idle(60);

    // Starts during a conversion are ignored; earliest restart at +22.
    issue(20'd57600, 2'd2,
          {6'd0, 6'd5, 6'd7, 6'd6, 6'd32, 6'd0},
          {6'd29, 6'd5, 6'd7, 6'd6, 6'd32, 6'd0}, 1'b1, e0);
    wait_until(e0 + 4);
    baud_val = 20'd1; parity = 2'd0; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    wait_until(e0 + 11);
    baud_val = 20'd2; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    wait_until(e0 + 21);
    issue(20'd300, 2'd1,
          {6'd0, 6'd0, 6'd0, 6'd3, 6'd0, 6'd32},
          {6'd29, 6'd29, 6'd29, 6'd3, 6'd0, 6'd32}, 1'b1, e1);
    check("restart_edge", e1, e0 + 22);
    wait_idle(60);

    // Reset in mid-conversion aborts with no done.
    issue(20'd38400, 2'd1, 36'd0, 36'd0, 1'b0, e0);
    wait_until(e0 + 10);
    rst = 1'b0;
    #1;
    check("abort_dig0", int'(dig0), 29);
    check("abort_dig3", int'(dig3), 29);
    check("abort_busy", int'(busy), 0);
    check("abort_done", int'(done), 0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    repeat (30) @(posedge clk);
    #1;
    check("post_abort_dig1", int'(dig1), 29);
    issue(20'd19200, 2'd0,
          {6'd0, 6'd1, 6'd9, 6'd2, 6'd0, 6'd0},
          {6'd29, 6'd1, 6'd9, 6'd2, 6'd0, 6'd0}, 1'b1, e0);
    wait_idle(60);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
